memory_loader: RTL and testbench

Upstream loader for the 256 x 16 data/program memory. Accepts a byte stream over a valid/ready handshake, assembles 16-bit words, and drives the memory's write port (address, data, write enable). It raises a hold to the core while loading. After checking a trailing checksum, it reports done or error.

---
 rtl/memory_loader_if.sv | 25 ++
 rtl/memory_loader.sv | 112 +++++++++++
 tb/tb_memory_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_loader_if.sv
// Byte-stream input and memory write-port bundle for memory_loader.
// slave = the loader itself, master = the stream source / observer side.
interface memory_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_addr, mem_data, mem_we, busy, done, error, word_count
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_addr, mem_data, mem_we, busy, done, error, word_count
    );
endinterface

// File: rtl/memory_loader.sv
// Streams length / 2N data bytes / checksum into a DEPTH-word memory, raising
// busy (core hold) meanwhile and leaving a sticky done or error verdict.
module memory_loader #(
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic          clk,
    input  logic          rst,
    memory_loader_if.slave ld
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] BASE_W = AW'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, hi_q, sum_q;
    logic [AW-1:0] idx_q;
    logic [8:0]    wc_q;
    logic [15:0]   addr_q, data_q;
    logic          rdy_q, we_q, busy_q, done_q, err_q;

    logic          accept;
    logic          last_word;
    logic [AW-1:0] waddr;

    assign accept    = rdy_q & ld.in_valid;
    assign last_word = (wc_q + 9'd1) == {1'b0, len_q};
    // Address arithmetic in AW bits gives the modulo-DEPTH wrap for free.
    assign waddr     = BASE_W + idx_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ld.start) state_d = S_LEN;
            S_LEN:   if (accept) state_d = (ld.in_data == 8'd0) ? S_ERR : S_HI;
            S_HI:    if (accept) state_d = S_LO;
            S_LO:    if (accept) state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_CSUM : S_HI;
            S_CSUM:  if (accept) state_d = (ld.in_data == sum_q) ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:   if (ld.start) state_d = S_LEN;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            hi_q    <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            wc_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= state_d inside {S_LEN, S_HI, S_LO, S_CSUM};
            busy_q  <= state_d inside {S_LEN, S_HI, S_LO, S_WRITE, S_CSUM};
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
            we_q    <= (state_d == S_WRITE);

            if (state_d == S_LEN && state_q != S_LEN) begin
                idx_q <= '0;
                sum_q <= '0;
                wc_q  <= '0;
            end

            case (state_q)
                S_LEN: if (accept) len_q <= ld.in_data;
                S_HI: begin
                    if (accept) begin
                        hi_q  <= ld.in_data;
                        sum_q <= sum_q + ld.in_data;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        data_q <= {hi_q, ld.in_data};
                        addr_q <= 16'(waddr);
                        sum_q  <= sum_q + ld.in_data;
                    end
                end
                S_WRITE: begin
                    idx_q <= idx_q + 1'b1;
                    wc_q  <= wc_q + 9'd1;
                end
                default: ;
            endcase
        end
    end

    assign ld.in_ready   = rdy_q;
    assign ld.mem_addr   = addr_q;
    assign ld.mem_data   = data_q;
    assign ld.mem_we     = we_q;
    assign ld.busy       = busy_q;
    assign ld.done       = done_q;
    assign ld.error      = err_q;
    assign ld.word_count = wc_q;
endmodule

// File: tb/tb_memory_loader.sv
// Directed plus random load sessions against two loaders (base 0x00 and 0xFE),
// checked against a stream-level model of memory contents and verdicts.
module tb_memory_loader;
    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       drv_start = 1'b0;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data  = 8'h00;
    int         sel       = 0;

    memory_loader_if if0 ();
    memory_loader_if if1 ();

    assign if0.start    = drv_start && (sel == 0);
    assign if0.in_valid = drv_valid && (sel == 0);
    assign if0.in_data  = drv_data;
    assign if1.start    = drv_start && (sel == 1);
    assign if1.in_valid = drv_valid && (sel == 1);
    assign if1.in_data  = drv_data;

    memory_loader #(.BASE_ADDR(0),     .DEPTH(256)) u0 (.clk(clk), .rst(rst), .ld(if0));
    memory_loader #(.BASE_ADDR('hFE),  .DEPTH(256)) u1 (.clk(clk), .rst(rst), .ld(if1));

    logic        o_ready, o_we, o_busy, o_done, o_err;
    logic [15:0] o_addr, o_data;
    logic [8:0]  o_wc;
    assign o_ready = sel ? if1.in_ready   : if0.in_ready;
    assign o_we    = sel ? if1.mem_we     : if0.mem_we;
    assign o_busy  = sel ? if1.busy       : if0.busy;
    assign o_done  = sel ? if1.done       : if0.done;
    assign o_err   = sel ? if1.error      : if0.error;
    assign o_addr  = sel ? if1.mem_addr   : if0.mem_addr;
    assign o_data  = sel ? if1.mem_data   : if0.mem_data;
    assign o_wc    = sel ? if1.word_count : if0.word_count;

    // Memory behind each loader, and the expected image
    logic [15:0] mem     [2][256] = '{default: '0};
    logic [15:0] exp_mem [2][256] = '{default: '0};
    int          we_cnt  [2]      = '{0, 0};
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (if0.mem_we) begin
            mem[0][if0.mem_addr[7:0]] <= if0.mem_data;
            we_cnt[0] <= we_cnt[0] + 1;
        end
        if (if1.mem_we) begin
            mem[1][if1.mem_addr[7:0]] <= if1.mem_data;
            we_cnt[1] <= we_cnt[1] + 1;
        end
    end

    int checks   = 0;
    int failures = 0;
    int st_cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, o_ready, 0);
        check({tag, "_we"},    o_we,    0);
        check({tag, "_addr"},  o_addr,  0);
        check({tag, "_data"},  o_data,  0);
        check({tag, "_busy"},  o_busy,  0);
        check({tag, "_done"},  o_done,  0);
        check({tag, "_err"},   o_err,   0);
        check({tag, "_wc"},    o_wc,    0);
    endtask

    task automatic cmp_mem(input string tag, input int d);
        int bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[d][i] !== exp_mem[d][i]) bad++;
        check({tag, "_mem"}, bad, 0);
    endtask

    task automatic do_start();
        drv_start = 1'b1;
        @(negedge clk);
        drv_start = 1'b0;
        st_cyc = cyc;
        check("start_busy",  o_busy,  1);
        check("start_ready", o_ready, 1);
    endtask

    // mode 0: valid held high; 1: valid pattern 1-0-0-1; 2: random gaps + stray starts
    task automatic send_bytes(input byte_q_t bq, input int mode);
        int   i = 0;
        int   k = 0;
        int   wait_c = 0;
        logic v;
        logic acc;
        while (i < bq.size() && wait_c <= 20) begin
            v = 1'b1;
            if (mode == 1)      v = (k % 4 == 0) || (k % 4 == 3);
            else if (mode == 2) v = ($urandom_range(0, 2) != 0);
            drv_valid = v;
            drv_data  = v ? bq[i] : 8'($urandom);
            drv_start = (mode == 2) && ($urandom_range(0, 7) == 0);
            acc = v && o_ready;
            @(negedge clk);
            k++;
            if (acc) begin
                i++;
                wait_c = 0;
            end else begin
                wait_c++;
            end
        end
        drv_valid = 1'b0;
        drv_start = 1'b0;
        check("bytes_accepted", i, bq.size());
    endtask

    // Stream-level reference: what the image and verdict must be after bq.
    task automatic model(input int d, input byte_q_t bq, output logic exp_done,
                         output logic exp_err, output int exp_wc, output int exp_cyc);
        int         n;
        logic [7:0] s;
        n = bq[0];
        s = 8'h00;
        if (n == 0) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_wc   = 0;
            exp_cyc  = 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_mem[d][((d ? 254 : 0) + i) % 256] = {bq[1 + 2*i], bq[2 + 2*i]};
                s = s + bq[1 + 2*i] + bq[2 + 2*i];
            end
            exp_done = (bq[2*n + 1] == s);
            exp_err  = !exp_done;
            exp_wc   = n;
            exp_cyc  = 3 * n + 2;
        end
    endtask

    task automatic run_session(input string tag, input int d, input byte_q_t bq, input int mode);
        logic ed, ee;
        int   ewc, ecyc, we0;
        sel = d;
        we0 = we_cnt[d];
        do_start();
        send_bytes(bq, mode);
        model(d, bq, ed, ee, ewc, ecyc);
        check({tag, "_done"},  o_done,  ed);
        check({tag, "_err"},   o_err,   ee);
        check({tag, "_wc"},    o_wc,    ewc);
        check({tag, "_busy"},  o_busy,  0);
        check({tag, "_ready"}, o_ready, 0);
        check({tag, "_we_pulses"}, we_cnt[d] - we0, ewc);
        if (mode == 0) check({tag, "_cycles"}, cyc - st_cyc, ecyc);
        cmp_mem(tag, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t bq;
        int      n, we0;
        logic [7:0] s;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            check_reset_outputs("reset");
        end
        @(negedge clk);

        bq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        run_session("basic", 0, bq, 0);

        bq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        run_session("badsum", 0, bq, 0);

        bq = '{8'h00};
        run_session("zerolen", 0, bq, 0);

        bq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        run_session("gaps", 0, bq, 1);

        bq = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h06};
        run_session("wrap", 1, bq, 0);

        // Reset mid-load after the first word; mem[1] must keep 0xABCD.
        sel = 0;
        we0 = we_cnt[0];
        do_start();
        bq = '{8'h02, 8'h12, 8'h34};
        send_bytes(bq, 0);
        @(negedge clk);
        exp_mem[0][0] = 16'h1234;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        check("midrst_we_pulses", we_cnt[0] - we0, 1);
        cmp_mem("midrst", 0);
        bq = '{8'h02, 8'h12, 8'h34, 8'h5A, 8'h5A, 8'hFA};
        run_session("after_rst", 0, bq, 0);

        for (int r = 0; r < 24; r++) begin
            n = $urandom_range(1, 16);
            s = 8'h00;
            bq = {};
            bq.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) begin
                bq.push_back(8'($urandom));
                s = s + bq[$];
            end
            if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
            bq.push_back(s);
            run_session("rand", int'($urandom_range(0, 1)), bq, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
